// File: rtl/char_mem_arbiter.sv
// char_mem_arbiter: shares the single read/write port of the character memory
// between the HPS command path (requester 0) and the text engine (requester 1).
// Round-robin arbitration with an optional burst lock. One access is accepted
// per cycle. Read data is routed back to its owner after a fixed latency by a
// tag pipeline that runs alongside the memory.
module char_mem_arbiter #(
    parameter int M_WIDTH = 8,
    parameter int ADDR_W  = 13,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    // requester 0
    input  logic               req0,
    input  logic               we0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [M_WIDTH-1:0] wdata0,
    input  logic               lock0,
    output logic               gnt0,
    output logic               rvalid0,
    output logic [M_WIDTH-1:0] rdata0,
    // requester 1
    input  logic               req1,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [M_WIDTH-1:0] wdata1,
    input  logic               lock1,
    output logic               gnt1,
    output logic               rvalid1,
    output logic [M_WIDTH-1:0] rdata1,
    // memory port
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [M_WIDTH-1:0] mem_wdata,
    input  logic [M_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_t;

    owner_t              r_owner;
    owner_t              w_owner_next;
    logic                r_last_gnt;     // id of the most recent grantee
    logic [RD_LAT:0]     r_tag_valid;    // read-tag pipe: valid bits
    logic [RD_LAT:0]     r_tag_id;       // read-tag pipe: requester ids
    logic [M_WIDTH-1:0]  r_rdata0;
    logic [M_WIDTH-1:0]  r_rdata1;
    logic                w_rd_valid;
    logic                w_rd_id;

    // Owner register: tracks which requester, if any, holds a burst lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    // Arbitration and next owner: a locked owner is served exclusively (or
    // nobody is, while it idles); otherwise round-robin against last_gnt.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        w_owner_next = r_owner;
        if (rst_n) begin
            if (r_owner == OWN_0) begin
                gnt0 = req0;
            end else if (r_owner == OWN_1) begin
                gnt1 = req1;
            end else if (req0 && req1) begin
                gnt0 = r_last_gnt;
                gnt1 = !r_last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        // Lock is only taken by the requester granted this cycle and is
        // released as soon as the owner's lock input is seen low.
        if (gnt0 && lock0) begin
            w_owner_next = OWN_0;
        end else if (gnt1 && lock1) begin
            w_owner_next = OWN_1;
        end else if ((r_owner == OWN_0) && !lock0) begin
            w_owner_next = OWN_NONE;
        end else if ((r_owner == OWN_1) && !lock1) begin
            w_owner_next = OWN_NONE;
        end
    end

    // Remember who was granted last so contention alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (gnt1) begin
            r_last_gnt <= 1'b1;
        end else if (gnt0) begin
            r_last_gnt <= 1'b0;
        end
    end

    // Register the granted access onto the memory port; write strobe is a
    // single-cycle pulse, address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (gnt0) begin
            mem_addr  <= addr0;
            mem_we    <= we0;
            mem_wdata <= wdata0;
        end else if (gnt1) begin
            mem_addr  <= addr1;
            mem_we    <= we1;
            mem_wdata <= wdata1;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    assign w_rd_valid = (gnt0 && !we0) || (gnt1 && !we1);
    assign w_rd_id    = gnt1;

    // Tag pipe: stage 0 is valid while the address is on the memory port,
    // stage RD_LAT lines up with the returning read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_valid <= '0;
            r_tag_id    <= '0;
        end else begin
            r_tag_valid <= {r_tag_valid[RD_LAT-1:0], w_rd_valid};
            r_tag_id    <= {r_tag_id[RD_LAT-1:0], w_rd_id};
        end
    end

    assign rvalid0 = r_tag_valid[RD_LAT] && !r_tag_id[RD_LAT];
    assign rvalid1 = r_tag_valid[RD_LAT] &&  r_tag_id[RD_LAT];

    // Hold the last delivered word per requester so rdata is stable between returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (rvalid0) r_rdata0 <= mem_rdata;
            if (rvalid1) r_rdata1 <= mem_rdata;
        end
    end

    assign rdata0 = rvalid0 ? mem_rdata : r_rdata0;
    assign rdata1 = rvalid1 ? mem_rdata : r_rdata1;

endmodule

// File: tb/tb_char_mem_arbiter.sv
// Directed testbench for char_mem_arbiter with a behavioural 8192x8 memory
// (one-cycle registered read, write on mem_we).
module tb_char_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, lock0, gnt0, rvalid0;
    logic [12:0] addr0;
    logic [7:0]  wdata0, rdata0;
    logic        req1, we1, lock1, gnt1, rvalid1;
    logic [12:0] addr1;
    logic [7:0]  wdata1, rdata1;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  tb_mem [0:8191];
    int          n_cmp = 0;
    int          n_err = 0;

    always #10 clk = ~clk;

    char_mem_arbiter #(.M_WIDTH(8), .ADDR_W(13), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural character memory: registered read, read-before-write.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
        n_cmp++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
        n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1}); end
        n_cmp++; if ({rdata0, rdata1} !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h expected 0000", {rdata0, rdata1}); end
        n_cmp++; if ({mem_addr, mem_we, mem_wdata} !== 22'h0) begin n_err++; $display("FAIL reset_mem: got %h/%b/%h expected 0/0/0", mem_addr, mem_we, mem_wdata); end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_read();
        req0 = 1; we0 = 0; addr0 = 13'h0010;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL read_gnt: got %b expected 10", {gnt0, gnt1}); end
        tick();
        req0 = 0;
        @(negedge clk);
        n_cmp++; if (mem_addr !== 13'h0010 || mem_we !== 1'b0) begin n_err++; $display("FAIL read_mem_addr: got %h/%b expected 0010/0", mem_addr, mem_we); end
        n_cmp++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL read_rvalid_early: got %b expected 0", rvalid0); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h41) begin n_err++; $display("FAIL read_data: got %b/%h expected 1/41", rvalid0, rdata0); end
        n_cmp++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL read_rvalid1: got %b expected 0", rvalid1); end
        tick();
        $display("test_read: addr 0010 -> %h", rdata0);
    endtask

    task automatic test_lock();
        req0 = 1; we0 = 0; addr0 = 13'h0100;
        for (int k = 0; k < 4; k++) begin
            req1 = 1; we1 = 1; addr1 = 13'h0100 + 13'(k); wdata1 = 8'hA0 + 8'(k);
            lock1 = (k < 3);
            @(negedge clk);
            n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_err++; $display("FAIL lock_gnt%0d: got %b expected 01", k, {gnt0, gnt1}); end
            if (k > 0) begin
                n_cmp++; if (mem_addr !== 13'h0100 + 13'(k - 1) || mem_we !== 1'b1) begin n_err++; $display("FAIL lock_mem%0d: got %h/%b expected %h/1", k, mem_addr, mem_we, 13'h0100 + 13'(k - 1)); end
            end
            tick();
        end
        req1 = 0; we1 = 0; lock1 = 0;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL lock_release_gnt: got %b expected 10", {gnt0, gnt1}); end
        n_cmp++; if (mem_addr !== 13'h0103 || mem_wdata !== 8'hA3 || mem_we !== 1'b1) begin n_err++; $display("FAIL lock_last_write: got %h/%h/%b expected 0103/a3/1", mem_addr, mem_wdata, mem_we); end
        tick();
        req0 = 0;
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 13'h0100) begin n_err++; $display("FAIL lock_read_addr: got %h/%b expected 0100/0", mem_addr, mem_we); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid0 !== 1'b1 || rdata0 !== 8'hA0) begin n_err++; $display("FAIL lock_readback: got %b/%h expected 1/a0", rvalid0, rdata0); end
        tick();
        $display("test_lock: 4 locked writes, readback %h", rdata0);
    endtask

    task automatic test_raw();
        req1 = 1; we1 = 1; addr1 = 13'h0200; wdata1 = 8'h5A;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_err++; $display("FAIL raw_wgnt: got %b expected 01", {gnt0, gnt1}); end
        tick();
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 13'h0200;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL raw_rgnt: got %b expected 10", {gnt0, gnt1}); end
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 13'h0200 || mem_wdata !== 8'h5A) begin n_err++; $display("FAIL raw_write: got %h/%h/%b expected 0200/5a/1", mem_addr, mem_wdata, mem_we); end
        tick();
        req0 = 0;
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL raw_we_pulse: got %b expected 0", mem_we); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A) begin n_err++; $display("FAIL raw_data: got %b/%h expected 1/5a", rvalid0, rdata0); end
        n_cmp++; if (rvalid1 !== 1'b0 || rdata1 !== 8'h00) begin n_err++; $display("FAIL raw_rdata1_hold: got %b/%h expected 0/00", rvalid1, rdata1); end
        tick();
        $display("test_raw: write 5a then read -> %h", rdata0);
    endtask

    task automatic test_contention();
        logic exp_gnt1;
        logic exp_rv0, exp_rv1;
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            req0 = (k < 4); we0 = 0; addr0 = 13'h0020;
            req1 = (k < 4); we1 = 0; addr1 = 13'h0021;
            @(negedge clk);
            if (k < 4) begin
                exp_gnt1 = (k % 2 == 1);
                n_cmp++; if ({gnt0, gnt1} !== {!exp_gnt1, exp_gnt1}) begin n_err++; $display("FAIL cont_gnt%0d: got %b expected %b", k, {gnt0, gnt1}, {!exp_gnt1, exp_gnt1}); end
            end
            exp_rv0 = (k == 2) || (k == 4);
            exp_rv1 = (k == 3) || (k == 5);
            n_cmp++; if ({rvalid0, rvalid1} !== {exp_rv0, exp_rv1}) begin n_err++; $display("FAIL cont_rvalid%0d: got %b expected %b", k, {rvalid0, rvalid1}, {exp_rv0, exp_rv1}); end
            if (k == 5) begin
                n_cmp++; if (rdata0 !== 8'h50 || rdata1 !== 8'h51) begin n_err++; $display("FAIL cont_rdata: got %h/%h expected 50/51", rdata0, rdata1); end
            end
            tick();
        end
        idle_inputs();
        $display("test_contention: alternating grants checked");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 11; k++) begin
            req1 = (k < 8); we1 = 0; addr1 = 13'(k);
            @(negedge clk);
            if (k < 8) begin
                n_cmp++; if (gnt1 !== 1'b1) begin n_err++; $display("FAIL b2b_gnt%0d: got %b expected 1", k, gnt1); end
            end
            if (k >= 2 && k < 10) begin
                n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h30 + 8'(k - 2)) begin n_err++; $display("FAIL b2b_data%0d: got %b/%h expected 1/%h", k, rvalid1, rdata1, 8'h30 + 8'(k - 2)); end
            end else begin
                n_cmp++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL b2b_rvalid%0d: got %b expected 0", k, rvalid1); end
            end
            tick();
        end
        idle_inputs();
        $display("test_back_to_back: 8 pipelined reads");
    endtask

    task automatic test_reset_midflight();
        req0 = 1; we0 = 0; addr0 = 13'h0030;
        tick();
        addr0 = 13'h0031;
        tick();
        req0 = 0;
        rst_n = 0;
        @(negedge clk);
        n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_err++; $display("FAIL rstmid_rvalid_a: got %b expected 00", {rvalid0, rvalid1}); end
        n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 13'h0000) begin n_err++; $display("FAIL rstmid_mem: got %h/%b expected 0000/0", mem_addr, mem_we); end
        tick();
        rst_n = 1;
        req0 = 1; we0 = 0; addr0 = 13'h0005;
        req1 = 1; we1 = 0; addr1 = 13'h0006;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL rstmid_first_gnt: got %b expected 10", {gnt0, gnt1}); end
        n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_err++; $display("FAIL rstmid_rvalid_b: got %b expected 00", {rvalid0, rvalid1}); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_err++; $display("FAIL rstmid_rvalid_c: got %b expected 00", {rvalid0, rvalid1}); end
        tick();
        @(negedge clk);
        n_cmp++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h35) begin n_err++; $display("FAIL rstmid_after: got %b/%h expected 1/35", rvalid0, rdata0); end
        tick();
        $display("test_reset_midflight: in-flight reads flushed");
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) tb_mem[i] = 8'(i + 48);
        tb_mem[16] = 8'h41;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_read();
        test_lock();
        test_raw();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
